// File: rtl/h_serial_adder.sv
// Bit-serial 16-bit adder: one bit per clock, LSB first, with carry-out and
// two's-complement overflow reported on a one-cycle done pulse.
module h_serial_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [15:0] a_sh, b_sh;
   logic        carry;
   logic [3:0]  cnt;
   logic        bit_sum, bit_carry;
   logic        last_bit;

   // Full-adder slice for the bit currently at the bottom of the shifters.
   assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
   assign bit_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign last_bit  = (cnt == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= 16'h0000;
         b_sh  <= 16'h0000;
         carry <= 1'b0;
         cnt   <= 4'd0;
         sum   <= 16'h0000;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= 4'd0;
                  sum   <= 16'h0000;
                  cout  <= 1'b0;
                  ovf   <= 1'b0;
               end
            end
            RUN: begin
               sum   <= {bit_sum, sum[15:1]};
               a_sh  <= {1'b0, a_sh[15:1]};
               b_sh  <= {1'b0, b_sh[15:1]};
               carry <= bit_carry;
               cnt   <= cnt + 4'd1;
               // On bit 15, carry still holds the carry into the sign bit.
               if (last_bit) begin
                  cout <= bit_carry;
                  ovf  <= carry ^ bit_carry;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_h_serial_adder.sv
// Scoreboard bench for h_serial_adder: expected results are queued when an
// operation is started and compared whenever done is observed.
module tb_h_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        cin;
   logic [15:0] sum;
   logic        cout, ovf, busy, done;

   h_serial_adder dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } result_t;

   result_t sb_q[$];
   result_t last_exp;
   int pass_cnt = 0;
   int total_cnt = 0;
   int done_seen = 0;
   int cyc = 0;
   int last_done_cyc = 0;
   bit last_done_valid = 0;
   bit regress = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic result_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
      result_t r;
      logic [16:0] full;
      full   = {1'b0, x} + {1'b0, y} + {16'h0000, ci};
      r.sum  = full[15:0];
      r.cout = full[16];
      r.ovf  = (x[15] == y[15]) && (r.sum[15] != x[15]);
      return r;
   endfunction

   // Output monitor: every done pulse consumes one queued expectation.
   always @(negedge clk) begin
      cyc++;
      if (done) begin
         result_t e;
         done_seen++;
         if (sb_q.size() == 0) begin
            check("done_without_op", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sum", {16'h0, sum}, {16'h0, e.sum});
            check("cout", {31'h0, cout}, {31'h0, e.cout});
            check("ovf", {31'h0, ovf}, {31'h0, e.ovf});
            $display("op done: sum=%h cout=%b ovf=%b (exp %h %b %b)",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
         if (regress && last_done_valid)
            check("done_spacing", cyc - last_done_cyc, 32'd18);
         last_done_cyc   = cyc;
         last_done_valid = 1'b1;
      end
   end

   // Runs one operation from IDLE; optional operand change and stray starts.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input bit change_ops, input bit stray_start);
      int d0;
      @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      last_exp = model(x, y, ci);
      sb_q.push_back(last_exp);
      d0 = done_seen;
      @(negedge clk);
      start = 1'b0;
      if (change_ops) begin
         a = 16'h1234; b = 16'h1234; cin = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         check("busy_run", {31'h0, busy}, 32'd1);
         check("done_run", {31'h0, done}, 32'd0);
         if (stray_start) start = (i == 5);
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", {31'h0, done}, 32'd1);
      check("busy_done", {31'h0, busy}, 32'd0);
      if (stray_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_clear", {31'h0, done}, 32'd0);
      check("busy_idle", {31'h0, busy}, 32'd0);
      check("sum_hold", {16'h0, sum}, {16'h0, last_exp.sum});
      @(negedge clk);
      check("busy_idle2", {31'h0, busy}, 32'd0);
      check("done_count", done_seen - d0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sum", {16'h0, sum}, 32'h0);
      check("rst_cout", {31'h0, cout}, 32'd0);
      check("rst_ovf", {31'h0, ovf}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {31'h0, busy}, 32'd0);

      run_op(16'h0003, 16'h0005, 1'b0, 0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0);
      run_op(16'h8000, 16'h8000, 1'b1, 1, 0);
      run_op(16'h1357, 16'h2468, 1'b1, 0, 1);

      // Abort mid-RUN at cycle 7; the queued expectation is withdrawn.
      @(negedge clk);
      a = 16'hF0F0; b = 16'h0F0F; cin = 1'b1; start = 1'b1;
      sb_q.push_back(model(a, b, cin));
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_busy_before", {31'h0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_sum", {16'h0, sum}, 32'h0);
      check("abort_cout", {31'h0, cout}, 32'd0);
      check("abort_ovf", {31'h0, ovf}, 32'd0);
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_done", {31'h0, done}, 32'd0);
      void'(sb_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_done", {31'h0, done}, 32'd0);
      run_op(16'h1111, 16'h2222, 1'b0, 0, 0);

      // Back-to-back regression with start held high.
      last_done_valid = 1'b0;
      regress = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         sb_q.push_back(model(a, b, cin));
         repeat (18) @(negedge clk);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("queue_drained", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/h_serial_adder.md
H_SERIAL_ADDER -- requirements
Module: h_serial_adder

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition; sampled on clk rising edge.
REQ-005 The block SHALL have port a, input, 16 bits: first operand, captured only when start is accepted.
REQ-006 The block SHALL have port b, input, 16 bits: second operand, captured only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured only when start is accepted.
REQ-008 The block SHALL have port sum, output, 16 bits: result register, a+b+cin modulo 2^16.
REQ-009 The block SHALL have port cout, output, 1 bit: carry out of bit 15.
REQ-010 The block SHALL have port ovf, output, 1 bit: two's-complement overflow, carry into bit 15 XOR carry out of bit 15.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle pulse marking valid sum/cout/ovf.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL latch a, b and cin into internal shift/carry registers, clear the bit counter to 0, clear sum, and enter RUN.
REQ-015 In RUN, each rising edge SHALL process one bit LSB-first: sum bit = a_i XOR b_i XOR c; next c = (a_i AND b_i) OR (c AND (a_i XOR b_i)); the sum bit is shifted into sum from the MSB side; the operand registers shift right by one.
REQ-016 The bit counter SHALL increment once per RUN edge; the edge on which the counter equals 15 processes bit 15, records the carry into bit 15, and transitions to DONE.
REQ-017 On entering DONE, sum SHALL hold the full result, cout the final carry and ovf the carry-into-15 XOR cout.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in RUN (16 cycles) and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 exactly in DONE (one cycle).
REQ-021 Latency: start accepted at edge N; done high during the cycle after edge N+16; 17 edges start-to-done.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing; the operation in progress is unaffected.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-024 sum, cout and ovf SHALL hold their values from DONE through IDLE until the next accepted start; cout and ovf are cleared on acceptance.
REQ-025 Intermediate sum values during RUN are not valid; consumers SHALL qualify on done.
REQ-026 start held high continuously SHALL produce back-to-back operations every 18 cycles (IDLE acceptance, 16 RUN, 1 DONE).

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, counter 0, carry 0, operand registers 0, sum 16'h0000, cout 0, ovf 0, busy 0, done 0.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; after rst deasserts, the first edge with start=1 starts a fresh operation.
REQ-029 While rst=1, start SHALL be ignored.

Verification
REQ-030 a=16'h0003, b=16'h0005, cin=0, start 1 cycle -> busy 16 cycles, then done 1 cycle with sum=16'h0008, cout=0, ovf=0.
REQ-031 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
REQ-032 a=16'h8000, b=16'h8000, cin=1 -> sum=16'h0001, cout=1, ovf=1; a and b changed to 16'h1234 during RUN -> result unchanged.
REQ-033 start pulsed during RUN and during DONE -> ignored, exactly one done pulse, no second busy period.
REQ-034 rst asserted at RUN cycle 7 -> all outputs 0 immediately, no done; then a=16'h1111, b=16'h2222, cin=0 -> sum=16'h3333 after 17 edges.
REQ-035 Random regression: 1000 random a, b, cin with start held high -> each done shows sum/cout/ovf matching a reference model, done spacing exactly 18 cycles.
